// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;

   localparam int unsigned NIBBLES = 4;
   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   // Full-adder cell: returns {cout, sum}.
   function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
      return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
   endfunction

endpackage

// File: rtl/add_4bit_slice.sv
// Combinational 4-bit ripple adder; also exports the carry into bit 3 for overflow.
module add_4bit_slice
   import addsub_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       c3
);

   always_comb begin : p_ripple
      logic       cy;
      logic [1:0] r;
      s  = '0;
      c3 = 1'b0;
      cy = cin;
      r  = '0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) c3 = cy;
         r    = fa(a[i], b[i], cy);
         s[i] = r[0];
         cy   = r[1];
      end
      cout = cy;
   end

endmodule

// File: rtl/addsub_nibble_seq.sv
// 16-bit add/subtract done one nibble per cycle on a shared 4-bit slice, with
// optional saturation and registered result/flags behind a start/done handshake.
module addsub_nibble_seq
   import addsub_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        sub,
   input  logic        sat,
   output logic        busy,
   output logic        done,
   output logic [15:0] Sum,
   output logic        Ovfl,
   output logic        Z,
   output logic        N
);

   addsub_state_t state_q, state_d;

   logic [1:0]  idx_q;
   logic [15:0] a_q, b_q;
   logic        sub_q, sat_q, carry_q;
   logic [11:0] res_q;
   logic [15:0] sum_q;
   logic        ovfl_q, z_q, n_q;

   logic        accept, last;
   logic [3:0]  a_nib, b_nib, s_nib;
   logic        cout, c3;
   logic [15:0] raw_sum, sum_d;
   logic        ovf_raw;

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign last   = (state_q == RUN) && (idx_q == 2'd3);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == 2'd3) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_comb begin
      a_nib = 4'h0;
      b_nib = 4'h0;
      unique case (idx_q)
         2'd0: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
         2'd1: begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
         2'd2: begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
         2'd3: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
         default: ;
      endcase
      b_nib = b_nib ^ {4{sub_q}};
   end

   add_4bit_slice u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_q),
      .s    (s_nib),
      .cout (cout),
      .c3   (c3)
   );

   // Only meaningful on the last RUN cycle, when the top nibble comes straight off the slice.
   always_comb begin
      raw_sum = {s_nib, res_q};
      ovf_raw = cout ^ c3;
      sum_d   = raw_sum;
      if (sat_q && ovf_raw) sum_d = a_q[15] ? SAT_NEG : SAT_POS;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= 2'd0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sat_q   <= 1'b0;
         carry_q <= 1'b0;
         res_q   <= '0;
      end else if (accept) begin
         idx_q   <= 2'd0;
         a_q     <= A;
         b_q     <= B;
         sub_q   <= sub;
         sat_q   <= sat;
         carry_q <= sub;
         res_q   <= '0;
      end else if (state_q == RUN) begin
         idx_q   <= idx_q + 2'd1;
         carry_q <= cout;
         unique case (idx_q)
            2'd0:    res_q[3:0]  <= s_nib;
            2'd1:    res_q[7:4]  <= s_nib;
            2'd2:    res_q[11:8] <= s_nib;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q  <= '0;
         ovfl_q <= 1'b0;
         z_q    <= 1'b0;
         n_q    <= 1'b0;
      end else if (last) begin
         sum_q  <= sum_d;
         ovfl_q <= ovf_raw;
         z_q    <= (sum_d == 16'h0000);
         n_q    <= sum_d[15];
      end
   end

   assign Sum  = sum_q;
   assign Ovfl = ovfl_q;
   assign Z    = z_q;
   assign N    = n_q;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Bench for addsub_nibble_seq: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_addsub_nibble_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, sub, sat;
   logic [15:0] A, B;
   logic        busy, done, Ovfl, Z, N;
   logic [15:0] Sum;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   addsub_nibble_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .sub   (sub),
      .sat   (sat),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Ovfl  (Ovfl),
      .Z     (Z),
      .N     (N)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = idle, 1..4 = computing, 5 = result presented.
   int          m_phase = 0;
   logic [15:0] m_a, m_b, m_sum;
   logic        m_sub, m_sat, m_ovf, m_z, m_n;

   always @(posedge clk) begin
      int sa, sb, full;
      if (!rst_n) begin
         m_phase = 0;
         m_sum   = 16'h0;
         m_ovf   = 1'b0;
         m_z     = 1'b0;
         m_n     = 1'b0;
      end else if ((m_phase == 0 || m_phase == 5) && start) begin
         m_a = A; m_b = B; m_sub = sub; m_sat = sat;
         m_phase = 1;
      end else if (m_phase == 4) begin
         sa    = int'($signed(m_a));
         sb    = int'($signed(m_b));
         full  = m_sub ? sa - sb : sa + sb;
         m_ovf = (full > 32767) || (full < -32768);
         m_sum = full[15:0];
         if (m_sat && m_ovf) m_sum = m_a[15] ? 16'h8000 : 16'h7FFF;
         m_z   = (m_sum == 16'h0);
         m_n   = m_sum[15];
         m_phase = 5;
      end else if (m_phase >= 1 && m_phase <= 3) begin
         m_phase = m_phase + 1;
      end else if (m_phase == 5) begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, (m_phase >= 1 && m_phase <= 4));
         chk("done", done, (m_phase == 5));
         chk("Sum", Sum, m_sum);
         chk("Ovfl", Ovfl, m_ovf);
         chk("Z", Z, m_z);
         chk("N", N, m_n);
      end
   end

   // Launch one op; returns at the negedge where done is seen (or on timeout).
   // b2b: caller is already at a done negedge, so start is driven in that DONE cycle.
   // poke: pulse start with junk operands while RUN.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic st, input bit b2b, input bit poke,
                         input logic [15:0] e_sum, input logic e_ovf, input logic e_z,
                         input logic e_n);
      int cnt;
      bit got;
      if (!b2b) @(negedge clk);
      #1;
      A = a; B = b; sub = s; sat = st; start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      cnt = 1;
      got = 1'b0;
      while (!got && cnt < 12) begin
         @(negedge clk);
         cnt++;
         if (done) begin
            got = 1'b1;
         end else if (poke && cnt == 2) begin
            #1;
            A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0; sat = 1'b0; start = 1'b1;
         end else if (poke && cnt == 3) begin
            #1;
            start = 1'b0;
         end
      end
      chk({name, "_latency"}, cnt, 5);
      chk({name, "_Sum"}, Sum, e_sum);
      chk({name, "_Ovfl"}, Ovfl, e_ovf);
      chk({name, "_Z"}, Z, e_z);
      chk({name, "_N"}, N, e_n);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; sub = 1'b0; sat = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_Sum", Sum, 0);
      #1 rst_n = 1'b1;

      run_op("carry",   16'h0FFF, 16'h0001, 0, 0, 0, 0, 16'h1000, 0, 0, 0);
      run_op("neg",     16'h0005, 16'h0007, 1, 0, 0, 0, 16'hFFFE, 0, 0, 1);
      run_op("zero",    16'h1234, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 1, 0);
      run_op("ovf_raw", 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 1, 0, 1);
      run_op("ovf_sat", 16'h7FFF, 16'h0001, 0, 1, 0, 0, 16'h7FFF, 1, 0, 0);
      run_op("negsat1", 16'h8000, 16'h0001, 1, 1, 0, 0, 16'h8000, 1, 0, 1);
      run_op("negsat2", 16'h8000, 16'h8000, 0, 1, 0, 0, 16'h8000, 1, 0, 1);
      run_op("plain",   16'h1234, 16'h4321, 0, 1, 0, 0, 16'h5555, 0, 0, 0);
      run_op("poke",    16'h0100, 16'h0023, 0, 0, 0, 1, 16'h0123, 0, 0, 0);
      run_op("b2b_a",   16'h0002, 16'h0003, 1, 0, 0, 0, 16'hFFFF, 0, 0, 1);
      run_op("b2b_b",   16'h8000, 16'h8000, 0, 1, 1, 0, 16'h8000, 1, 0, 1);

      // Reset while RUN idx==2 discards the operation.
      @(negedge clk);
      #1;
      A = 16'h1234; B = 16'h1111; sub = 1'b0; sat = 1'b0; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_Sum", Sum, 0);
      chk("mid_rst_Ovfl", Ovfl, 0);
      chk("mid_rst_N", N, 0);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("no_done_after_rst", seen, 0);

      run_op("post_rst", 16'h0001, 16'h0001, 0, 0, 0, 0, 16'h0002, 0, 0, 0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
